// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART: state encoding, parity modes,
// per-frame shadow configuration and parity/format helper functions.
package uart_pkg;

  localparam int CFG_DIV_W  = 16;
  localparam int MAX_DATA_W = 9;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } tx_state_e;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic [3:0]           data_bits;
    logic [1:0]           parity;
    logic                 stop2;
  } uart_cfg_t;

  // Out-of-range frame lengths fall back to 8 data bits.
  function automatic logic [3:0] eff_data_bits(input logic [3:0] bits);
    if ((bits >= 4'd5) && (bits <= 4'd9)) begin
      return bits;
    end else begin
      return 4'd8;
    end
  endfunction

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  // Only the low n bits take part; odd parity inverts the XOR reduction.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic [3:0] n,
                                      input logic [1:0] mode);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < int'(n)) begin
        acc = acc ^ data[i];
      end else begin
        acc = acc;
      end
    end
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a one-cycle flush that beats any push/pop.
module sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       level_q;
  logic              do_push_s;
  logic              do_pop_s;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg_fifo.sv
// UART transmitter with run-time frame format, byte FIFO front end and break generation.
module uart_tx_cfg_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          break_req,
  input  logic                          flush,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [DATA_W-1:0]           fifo_rdata_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_s;
  logic                        pop_s;
  logic                        launch_s;
  logic                        bit_end_s;
  uart_cfg_t                   cfg_live_s;

  tx_state_e         state_q,    state_d;
  uart_cfg_t         cfg_q,      cfg_d;
  logic [DIV_W-1:0]  cnt_q,      cnt_d;
  logic [3:0]        bit_idx_q,  bit_idx_d;
  logic [DATA_W-1:0] shreg_q,    shreg_d;
  logic              par_q,      par_d;
  logic              stop_idx_q, stop_idx_d;
  logic              brk_rel_q,  brk_rel_d;
  logic              tx_q,       tx_d;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .pop_i   (pop_s),
    .flush_i (flush),
    .wdata_i (tx_data),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  assign cfg_live_s.div       = CFG_DIV_W'(cfg_div);
  assign cfg_live_s.data_bits = eff_data_bits(cfg_data_bits);
  assign cfg_live_s.parity    = cfg_parity;
  assign cfg_live_s.stop2     = cfg_stop2;
  assign bit_end_s            = (cnt_q == DIV_W'(cfg_q.div));

  assign tx         = tx_q;
  assign tx_ready   = !fifo_full_s;
  assign busy       = (state_q != IDLE) || !fifo_empty_s;
  assign fifo_level = fifo_level_s;

  // Bit sequencing; any frame or break end funnels into launch_s so the next frame starts with no gap.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    cnt_d      = cnt_q + DIV_W'(1);
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    stop_idx_d = stop_idx_q;
    brk_rel_d  = brk_rel_q;
    tx_d       = tx_q;
    pop_s      = 1'b0;
    launch_s   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        launch_s = 1'b1;
      end
      START: begin
        if (bit_end_s) begin
          state_d   = DATA;
          cnt_d     = '0;
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
          bit_idx_d = 4'd1;
        end else begin
          tx_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_idx_q == cfg_q.data_bits) begin
            if (parity_en(cfg_q.parity)) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          tx_d = tx_q;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_d    = STOP;
          cnt_d      = '0;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end else begin
          tx_d = tx_q;
        end
      end
      STOP: begin
        if (bit_end_s && cfg_q.stop2 && !stop_idx_q) begin
          stop_idx_d = 1'b1;
          cnt_d      = '0;
        end else if (bit_end_s) begin
          launch_s = 1'b1;
        end else begin
          tx_d = 1'b1;
        end
      end
      BREAK: begin
        // The recovery high period tracks the live divisor, not the shadow copy.
        if (break_req) begin
          tx_d      = 1'b0;
          cnt_d     = '0;
          brk_rel_d = 1'b0;
        end else if (!brk_rel_q) begin
          tx_d      = 1'b1;
          cnt_d     = '0;
          brk_rel_d = 1'b1;
        end else if (cnt_q == cfg_div) begin
          launch_s = 1'b1;
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (launch_s) begin
      cnt_d = '0;
      if (break_req) begin
        state_d   = BREAK;
        tx_d      = 1'b0;
        brk_rel_d = 1'b0;
      end else if (!fifo_empty_s) begin
        state_d = START;
        tx_d    = 1'b0;
        pop_s   = 1'b1;
        cfg_d   = cfg_live_s;
        shreg_d = fifo_rdata_s;
        par_d   = parity_bit(MAX_DATA_W'(fifo_rdata_s), cfg_live_s.data_bits, cfg_live_s.parity);
      end else begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // State and datapath registers; tx resets high so the line never glitches low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      stop_idx_q <= 1'b0;
      brk_rel_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_idx_q <= stop_idx_d;
      brk_rel_q  <= brk_rel_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg_fifo.sv
// Directed bench for uart_tx_cfg_fifo: frame shapes, parity, break, back-to-back, reset and flush.
module tb_uart_tx_cfg_fifo;

  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  cfg_div;
  logic [3:0]        cfg_data_bits;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              break_req;
  logic              flush;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx;
  logic              busy;
  logic [2:0]        fifo_level;

  int n_chk = 0;
  int n_bad = 0;

  logic [8:0]  t3_data [6];
  logic [15:0] t3_frame [4];
  logic [29:0] t4_seq;

  always #5 clk = ~clk;

  uart_tx_cfg_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .break_req     (break_req),
    .flush         (flush),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx            (tx),
    .busy          (busy),
    .fifo_level    (fifo_level)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [8:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
  endtask

  // bits[i] is the i-th bit on the wire (start first). hook selects per-cycle side stimulus.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int len,
                             input int per, input int hook);
    int k;
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c < per; c++) begin
        tick();
        k = b * per + c;
        check_val(tag, {31'd0, tx}, {31'd0, bits[b]});
        if (hook == 2) begin
          if (k == 0)  tx_valid = 1'b0;
          if (k == 12) cfg_div = 16'd7;
        end
        if (hook == 3) begin
          if (k == 0) tx_data = 9'h0F0;
          if (k == 1) tx_data = 9'h055;
          if (k == 2) begin
            check_val("flush_lvl_before", {29'd0, fifo_level}, 32'd3);
            flush   = 1'b1;
            tx_data = 9'h0AA;
          end
          if (k == 3) begin
            flush    = 1'b0;
            tx_valid = 1'b0;
            check_val("flush_lvl_after", {29'd0, fifo_level}, 32'd0);
            check_val("flush_ready", {31'd0, tx_ready}, 32'd1);
          end
        end
      end
    end
  endtask

  initial begin
    cfg_div       = 16'd3;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'd0;
    cfg_stop2     = 1'b0;
    break_req     = 1'b0;
    flush         = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 9'h000;
    t3_data  = '{9'h000, 9'h0FF, 9'h00F, 9'h0F0, 9'h055, 9'h0AA};
    t3_frame = '{16'h0200, 16'h03FE, 16'h021E, 16'h03E0};
    t4_seq   = {10'b10_0001_1110, 10'b11_1111_1110, 10'b10_0000_0000};

    #12;
    check_val("rst_tx", {31'd0, tx}, 32'd1);
    check_val("rst_ready", {31'd0, tx_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_level", {29'd0, fifo_level}, 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // 8N1, 0xA5, 4-clock bits
    push_one(9'h0A5);
    check_val("t1_latency", {31'd0, tx}, 32'd1);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    check_frame("t1_bit", 16'h034A, 10, 4, 0);
    tick();
    check_val("t1_idle", {31'd0, busy}, 32'd0);

    // 7 data bits, odd then even parity with two stop bits
    cfg_data_bits = 4'd7;
    cfg_parity    = 2'd1;
    push_one(9'h041);
    check_frame("t2_odd_bit", 16'h0382, 10, 4, 0);
    tick();
    cfg_parity = 2'd2;
    cfg_stop2  = 1'b1;
    push_one(9'h041);
    check_frame("t2_even_bit", 16'h0682, 11, 4, 0);
    tick();
    check_val("t2_idle", {31'd0, busy}, 32'd0);
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'd0;
    cfg_stop2     = 1'b0;

    // Break holds the line while the FIFO fills; release gives one high bit then frames
    break_req = 1'b1;
    tick();
    check_val("t3_brk_tx", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_data  = t3_data[i];
      check_val("t3_ready", {31'd0, tx_ready}, (i < 4) ? 32'd1 : 32'd0);
      tick();
      check_val("t3_level", {29'd0, fifo_level}, (i < 4) ? 32'(i + 1) : 32'd4);
    end
    tx_valid = 1'b0;
    repeat (5) tick();
    check_val("t3_hold_tx", {31'd0, tx}, 32'd0);
    check_val("t3_hold_lvl", {29'd0, fifo_level}, 32'd4);
    break_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t3_rel_high", {31'd0, tx}, 32'd1);
    end
    for (int f = 0; f < 4; f++) begin
      check_frame("t3_frame_bit", t3_frame[f], 10, 4, 0);
    end
    tick();
    check_val("t3_idle", {31'd0, busy}, 32'd0);

    // 1-clock bits, three words back-to-back
    cfg_div  = 16'd0;
    tx_valid = 1'b1;
    tx_data  = 9'h000;
    tick();
    check_val("t4_latency", {31'd0, tx}, 32'd1);
    tx_data = 9'h0FF;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0) tx_data = 9'h00F;
      if (i == 1) tx_valid = 1'b0;
      check_val("t4_bit", {31'd0, tx}, {31'd0, t4_seq[i]});
    end
    tick();
    check_val("t4_idle", {31'd0, busy}, 32'd0);

    // Divisor change mid-frame applies only from the next frame
    cfg_div  = 16'd3;
    tx_valid = 1'b1;
    tx_data  = 9'h000;
    tick();
    tx_data = 9'h0FF;
    check_val("t5_latency", {31'd0, tx}, 32'd1);
    check_frame("t5_div4_bit", 16'h0200, 10, 4, 2);
    check_frame("t5_div8_bit", 16'h03FE, 10, 8, 0);
    tick();
    check_val("t5_idle", {31'd0, busy}, 32'd0);
    cfg_div = 16'd3;

    // Asynchronous reset in the middle of DATA
    tx_valid = 1'b1;
    tx_data  = 9'h000;
    tick();
    tick();
    tx_valid = 1'b0;
    repeat (8) tick();
    check_val("t6_pre_tx", {31'd0, tx}, 32'd0);
    check_val("t6_pre_lvl", {29'd0, fifo_level}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_tx", {31'd0, tx}, 32'd1);
    check_val("t6_rst_lvl", {29'd0, fifo_level}, 32'd0);
    check_val("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
    check_val("t6_rst_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    push_one(9'h0A5);
    check_val("t6_latency", {31'd0, tx}, 32'd1);
    check_frame("t6_post_bit", 16'h034A, 10, 4, 0);
    tick();

    // Flush with three queued words while a frame is shifting
    tx_valid = 1'b1;
    tx_data  = 9'h0FF;
    tick();
    tx_data = 9'h00F;
    check_val("t7_latency", {31'd0, tx}, 32'd1);
    check_frame("t7_frame_bit", 16'h03FE, 10, 4, 3);
    tick();
    check_val("t7_idle", {31'd0, busy}, 32'd0);
    check_val("t7_tx", {31'd0, tx}, 32'd1);
    check_val("t7_lvl", {29'd0, fifo_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
